// File: rtl/vga_text_writer.sv
// Character-stream front end for the text-mode framebuffer: accepts ASCII bytes,
// tracks a cursor, interprets control codes and emits char+attribute words to VGA RAM.
module vga_text_writer #(
  parameter int         COLS       = 106,
  parameter int         ROWS       = 37,
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter logic [7:0] RESET_ATTR = 8'h07
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic [7:0]  ch,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic [7:0]  attr,
  input  logic        attr_we,
  output logic [14:0] vram_addr,
  output logic        vram_we,
  output logic [15:0] vram_data,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  localparam logic [14:0] TOTAL_M1 = 15'(ROWS * COLS - 1);
  localparam logic [14:0] COLS_A   = 15'(COLS);
  localparam logic [14:0] COLS_M1  = 15'(COLS - 1);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR_ROW,
    S_CLEAR_ALL
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [14:0] row_base_q, row_base_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic [14:0] clr_cnt_q, clr_cnt_d;
  logic [7:0]  attr_q, attr_d;
  logic        ch_ready_q, ch_ready_d;
  logic        busy_q, busy_d;
  logic        vram_we_q, vram_we_d;
  logic [14:0] vram_addr_q, vram_addr_d;
  logic [15:0] vram_data_q, vram_data_d;

  logic xfer;
  logic do_adv;

  // ch_ready_q is only ever high while in IDLE, so it alone qualifies a transfer
  assign xfer = ch_valid && ch_ready_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    clr_addr_d  = clr_addr_q;
    clr_cnt_d   = clr_cnt_q;
    attr_d      = attr_we ? attr : attr_q;
    vram_we_d   = 1'b0;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    do_adv      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          case (ch)
            CODE_LF: do_adv = 1'b1;
            CODE_CR: col_d = 7'd0;
            CODE_BS: begin
              if (col_q != 7'd0) begin
                col_d       = col_q - 7'd1;
                vram_we_d   = 1'b1;
                vram_addr_d = row_base_q + 15'(col_q) - 15'd1;
                vram_data_d = {attr_q, CLEAR_CHAR};
              end
            end
            CODE_FF: begin
              state_d    = S_CLEAR_ALL;
              clr_addr_d = 15'd0;
              clr_cnt_d  = TOTAL_M1;
            end
            default: begin
              vram_we_d   = 1'b1;
              vram_addr_d = row_base_q + 15'(col_q);
              vram_data_d = {attr_q, ch};
              if (col_q == LAST_COL) begin
                do_adv = 1'b1;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
          endcase

          // New line: move down (or wrap to the top) and blank it before accepting more
          if (do_adv) begin
            col_d     = 7'd0;
            state_d   = S_CLEAR_ROW;
            clr_cnt_d = COLS_M1;
            if (row_q == LAST_ROW) begin
              row_d      = 6'd0;
              row_base_d = 15'd0;
              clr_addr_d = 15'd0;
            end else begin
              row_d      = row_q + 6'd1;
              row_base_d = row_base_q + COLS_A;
              clr_addr_d = row_base_q + COLS_A;
            end
          end
        end
      end

      S_CLEAR_ROW, S_CLEAR_ALL: begin
        vram_we_d   = 1'b1;
        vram_addr_d = clr_addr_q;
        vram_data_d = {attr_q, CLEAR_CHAR};
        clr_addr_d  = clr_addr_q + 15'd1;
        clr_cnt_d   = clr_cnt_q - 15'd1;
        if (clr_cnt_q == 15'd0) begin
          state_d = S_IDLE;
          if (state_q == S_CLEAR_ALL) begin
            col_d      = 7'd0;
            row_d      = 6'd0;
            row_base_d = 15'd0;
          end
        end
      end

      default: state_d = S_CLEAR_ALL;
    endcase

    ch_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  // Reset lands directly in a full-screen clear so the screen is blank after power-up
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR_ALL;
      col_q       <= 7'd0;
      row_q       <= 6'd0;
      row_base_q  <= 15'd0;
      clr_addr_q  <= 15'd0;
      clr_cnt_q   <= TOTAL_M1;
      attr_q      <= RESET_ATTR;
      ch_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
      vram_we_q   <= 1'b0;
      vram_addr_q <= 15'd0;
      vram_data_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      clr_addr_q  <= clr_addr_d;
      clr_cnt_q   <= clr_cnt_d;
      attr_q      <= attr_d;
      ch_ready_q  <= ch_ready_d;
      busy_q      <= busy_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  assign ch_ready   = ch_ready_q;
  assign busy       = busy_q;
  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_data  = vram_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
